// File: rtl/draw_sched_pkg.sv
// -----------------------------------------------------------------------------
// draw_sched_pkg
// Shared definitions for the draw layer scheduler:
//   - FSM state encodings
//   - symbolic layer indices (draw order, bottom first)
//   - default widths and the default accept timeout
// -----------------------------------------------------------------------------
package draw_sched_pkg;

  typedef logic [2:0] sched_state_t;

  localparam sched_state_t IDLE        = 3'd0;
  localparam sched_state_t SELECT      = 3'd1;
  localparam sched_state_t ISSUE       = 3'd2;
  localparam sched_state_t WAIT_ACCEPT = 3'd3;
  localparam sched_state_t WAIT_DONE   = 3'd4;
  localparam sched_state_t NEXT        = 3'd5;
  localparam sched_state_t FRAME_DONE  = 3'd6;

  localparam int LAYER_BACKGROUND = 0;
  localparam int LAYER_FLOOR      = 1;
  localparam int LAYER_SPRITE     = 2;
  localparam int LAYER_OBSTACLE   = 3;

  localparam int DEF_NUM_LAYERS     = 4;
  localparam int DEF_X_BITWIDTH     = 8;
  localparam int DEF_Y_BITWIDTH     = 9;
  localparam int DEF_ID_BITWIDTH    = 4;
  localparam int DEF_ACCEPT_TIMEOUT = 64;

endpackage

// File: rtl/draw_layer_scheduler_edge_sync_detect.sv
// -----------------------------------------------------------------------------
// edge_sync_detect
// Two-flop synchroniser for a slow asynchronous strobe followed by a
// rising-edge detector. Reusable for any slow square wave / button input.
// Ports:
//   clock      in  system clock
//   reset_n    in  asynchronous active-low reset
//   async_in   in  asynchronous slow input
//   rise_pulse out one-cycle pulse on the first cycle a rising edge is seen
// -----------------------------------------------------------------------------
module edge_sync_detect (
  input  logic clock,
  input  logic reset_n,
  input  logic async_in,
  output logic rise_pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  always_comb begin
    sync1_d = async_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign rise_pulse = sync2_q & ~prev_q;

endmodule

// File: rtl/draw_layer_scheduler.sv
// -----------------------------------------------------------------------------
// draw_layer_scheduler
// Walks the shared DrawMif engine through NUM_LAYERS draw layers once per
// frame tick, using the engine's draw/ready handshake (ready falls = accepted,
// ready rises = finished). Layer 0 is drawn first.
// Ports:
//   clock, reset_n         clock, asynchronous active-low reset
//   frameTick              slow frame strobe; a rising edge starts a frame
//   layerEnable            per-layer enable (0 = skip)
//   xOriginBus/yOriginBus/romIdBus  packed per-layer origins and ROM IDs
//   ready                  engine idle flag
//   draw, xOrigin, yOrigin, ROMId   request and latched arguments to the engine
//   activeLayer            layer currently in service
//   busy                   high while a frame is in progress
//   layerDone              one-cycle pulse per layer (completed or skipped)
//   frameDone              one-cycle pulse at the end of the frame
//   timeoutError           sticky: a layer was never accepted in time
// Build option: define DRAW_SCHED_OVERRUN_CNT_EN to add overrunCount[7:0],
//   a saturating count of frame edges dropped while a frame was already pending.
// -----------------------------------------------------------------------------
module draw_layer_scheduler
  import draw_sched_pkg::*;
#(
  parameter int NUM_LAYERS     = DEF_NUM_LAYERS,
  parameter int X_BITWIDTH     = DEF_X_BITWIDTH,
  parameter int Y_BITWIDTH     = DEF_Y_BITWIDTH,
  parameter int ID_BITWIDTH    = DEF_ID_BITWIDTH,
  parameter int ACCEPT_TIMEOUT = DEF_ACCEPT_TIMEOUT,
  parameter int LAYER_BITS     = $clog2(NUM_LAYERS)
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             frameTick,
  input  logic [NUM_LAYERS-1:0]            layerEnable,
  input  logic [NUM_LAYERS*X_BITWIDTH-1:0] xOriginBus,
  input  logic [NUM_LAYERS*Y_BITWIDTH-1:0] yOriginBus,
  input  logic [NUM_LAYERS*ID_BITWIDTH-1:0] romIdBus,
  input  logic                             ready,
  output logic                             draw,
  output logic [X_BITWIDTH-1:0]            xOrigin,
  output logic [Y_BITWIDTH-1:0]            yOrigin,
  output logic [ID_BITWIDTH-1:0]           ROMId,
  output logic [LAYER_BITS-1:0]            activeLayer,
  output logic                             busy,
  output logic [NUM_LAYERS-1:0]            layerDone,
  output logic                             frameDone,
  output logic                             timeoutError
`ifdef DRAW_SCHED_OVERRUN_CNT_EN
  ,
  output logic [7:0]                       overrunCount
`endif
);

  localparam int TIMER_W = $clog2(ACCEPT_TIMEOUT) + 1;
  localparam logic [TIMER_W-1:0]    TIMER_LAST = TIMER_W'(ACCEPT_TIMEOUT - 1);
  localparam logic [LAYER_BITS-1:0] LAYER_LAST = LAYER_BITS'(NUM_LAYERS - 1);

  logic frame_edge;

  edge_sync_detect u_tick_sync (
    .clock      (clock),
    .reset_n    (reset_n),
    .async_in   (frameTick),
    .rise_pulse (frame_edge)
  );

  sched_state_t              state_q, state_d;
  logic [LAYER_BITS-1:0]     layer_q, layer_d;
  logic [TIMER_W-1:0]        timer_q, timer_d;
  logic                      pending_q, pending_d;
  logic [X_BITWIDTH-1:0]     x_q, x_d;
  logic [Y_BITWIDTH-1:0]     y_q, y_d;
  logic [ID_BITWIDTH-1:0]    id_q, id_d;
  logic [NUM_LAYERS-1:0]     layer_done_q, layer_done_d;
  logic                      frame_done_q, frame_done_d;
  logic                      timeout_err_q, timeout_err_d;
  logic [NUM_LAYERS-1:0]     layer_onehot;
  logic                      in_frame;
`ifdef DRAW_SCHED_OVERRUN_CNT_EN
  logic [7:0]                overrun_q, overrun_d;
`endif

  assign layer_onehot = NUM_LAYERS'(1) << layer_q;
  // FRAME_DONE is excluded: an edge there is absorbed as the pending frame.
  assign in_frame = (state_q != IDLE) && (state_q != FRAME_DONE);

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (frame_edge) state_d = SELECT;
      SELECT:      state_d = layerEnable[layer_q] ? ISSUE : NEXT;
      ISSUE:       state_d = WAIT_ACCEPT;
      WAIT_ACCEPT: begin
        // A low ready counts as acceptance even if the engine was already busy.
        if (!ready)                   state_d = WAIT_DONE;
        else if (timer_q == TIMER_LAST) state_d = NEXT;
      end
      WAIT_DONE:   if (ready) state_d = NEXT;
      NEXT:        state_d = (layer_q == LAYER_LAST) ? FRAME_DONE : SELECT;
      FRAME_DONE:  state_d = (pending_q || frame_edge) ? SELECT : IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    layer_d       = layer_q;
    timer_d       = timer_q;
    pending_d     = pending_q;
    x_d           = x_q;
    y_d           = y_q;
    id_d          = id_q;
    layer_done_d  = '0;
    frame_done_d  = 1'b0;
    timeout_err_d = timeout_err_q;
`ifdef DRAW_SCHED_OVERRUN_CNT_EN
    overrun_d     = overrun_q;
`endif

    if (in_frame && frame_edge) begin
      if (!pending_q) pending_d = 1'b1;
`ifdef DRAW_SCHED_OVERRUN_CNT_EN
      else if (overrun_q != 8'hFF) overrun_d = overrun_q + 8'd1;
`endif
    end

    case (state_q)
      IDLE: if (frame_edge) layer_d = '0;
      SELECT: begin
        if (layerEnable[layer_q]) begin
          x_d  = xOriginBus[int'(layer_q)*X_BITWIDTH +: X_BITWIDTH];
          y_d  = yOriginBus[int'(layer_q)*Y_BITWIDTH +: Y_BITWIDTH];
          id_d = romIdBus[int'(layer_q)*ID_BITWIDTH +: ID_BITWIDTH];
        end else begin
          layer_done_d = layer_onehot;
        end
      end
      // timer holds the index of the current draw-high cycle; ISSUE is cycle 0.
      ISSUE: timer_d = TIMER_W'(1);
      WAIT_ACCEPT: begin
        timer_d = timer_q + TIMER_W'(1);
        if (ready && (timer_q == TIMER_LAST)) begin
          timeout_err_d = 1'b1;
          layer_done_d  = layer_onehot;
        end
      end
      WAIT_DONE: if (ready) layer_done_d = layer_onehot;
      NEXT: begin
        if (layer_q == LAYER_LAST) frame_done_d = 1'b1;
        else                       layer_d = layer_q + LAYER_BITS'(1);
      end
      FRAME_DONE: begin
        // Pending and a same-cycle edge: consume one, keep the other pending.
        pending_d = pending_q & frame_edge;
        if (pending_q || frame_edge) layer_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      layer_q       <= '0;
      timer_q       <= '0;
      pending_q     <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      id_q          <= '0;
      layer_done_q  <= '0;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
`ifdef DRAW_SCHED_OVERRUN_CNT_EN
      overrun_q     <= '0;
`endif
    end else begin
      layer_q       <= layer_d;
      timer_q       <= timer_d;
      pending_q     <= pending_d;
      x_q           <= x_d;
      y_q           <= y_d;
      id_q          <= id_d;
      layer_done_q  <= layer_done_d;
      frame_done_q  <= frame_done_d;
      timeout_err_q <= timeout_err_d;
`ifdef DRAW_SCHED_OVERRUN_CNT_EN
      overrun_q     <= overrun_d;
`endif
    end
  end

  // draw and busy decode straight from the state so reset drops them at once.
  assign draw         = (state_q == ISSUE) || (state_q == WAIT_ACCEPT);
  assign busy         = (state_q != IDLE);
  assign activeLayer  = layer_q;
  assign xOrigin      = x_q;
  assign yOrigin      = y_q;
  assign ROMId        = id_q;
  assign layerDone    = layer_done_q;
  assign frameDone    = frame_done_q;
  assign timeoutError = timeout_err_q;
`ifdef DRAW_SCHED_OVERRUN_CNT_EN
  assign overrunCount = overrun_q;
`endif

endmodule

// File: tb/tb_draw_layer_scheduler.sv
// -----------------------------------------------------------------------------
// tb_draw_layer_scheduler
// Directed bench for draw_layer_scheduler with a simple DrawMif engine model:
// ready falls a few cycles after draw and rises 100 cycles later.
// -----------------------------------------------------------------------------
module tb_draw_layer_scheduler;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        frameTick = 1'b0;
  logic [3:0]  layerEnable = 4'hF;
  logic [31:0] xOriginBus = {8'd40, 8'd30, 8'd20, 8'd10};
  logic [35:0] yOriginBus = {9'd300, 9'd200, 9'd100, 9'd50};
  logic [15:0] romIdBus   = {4'd7, 4'd1, 4'd5, 4'd15};
  logic        ready;
  logic        draw;
  logic [7:0]  xOrigin;
  logic [8:0]  yOrigin;
  logic [3:0]  ROMId;
  logic [1:0]  activeLayer;
  logic        busy;
  logic [3:0]  layerDone;
  logic        frameDone;
  logic        timeoutError;
`ifdef DRAW_SCHED_OVERRUN_CNT_EN
  logic [7:0]  overrunCount;
`endif

  draw_layer_scheduler dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .frameTick    (frameTick),
    .layerEnable  (layerEnable),
    .xOriginBus   (xOriginBus),
    .yOriginBus   (yOriginBus),
    .romIdBus     (romIdBus),
    .ready        (ready),
    .draw         (draw),
    .xOrigin      (xOrigin),
    .yOrigin      (yOrigin),
    .ROMId        (ROMId),
    .activeLayer  (activeLayer),
    .busy         (busy),
    .layerDone    (layerDone),
    .frameDone    (frameDone),
    .timeoutError (timeoutError)
`ifdef DRAW_SCHED_OVERRUN_CNT_EN
    ,
    .overrunCount (overrunCount)
`endif
  );

  always #10 clock = ~clock;

  // Engine model
  logic       eng_on = 1'b1;
  logic       ready_drv = 1'b1;
  logic       eng_ready = 1'b1;
  logic [1:0] eng_phase = 2'd0;
  int         eng_cnt = 0;

  assign ready = eng_on ? eng_ready : ready_drv;

  always @(posedge clock) begin
    if (eng_on) begin
      case (eng_phase)
        2'd0: if (draw) begin eng_phase <= 2'd1; eng_cnt <= 1; end
        2'd1: if (eng_cnt == 3) begin eng_ready <= 1'b0; eng_phase <= 2'd2; eng_cnt <= 1; end
              else eng_cnt <= eng_cnt + 1;
        2'd2: if (eng_cnt == 100) begin eng_ready <= 1'b1; eng_phase <= 2'd0; end
              else eng_cnt <= eng_cnt + 1;
        default: eng_phase <= 2'd0;
      endcase
    end
  end

  // Monitor: logs draw requests, draw-high lengths, layerDone pulses, frames
  logic [3:0] rom_q[$];
  int         hi_q[$];
  logic [3:0] ld_q[$];
  int         fd_cnt = 0;
  int         streak = 0;
  logic       draw_prev = 1'b0;

  always @(negedge clock) begin
    draw_prev <= draw;
    streak    <= draw ? streak + 1 : 0;
    if (draw && !draw_prev) rom_q.push_back(ROMId);
    if (!draw && draw_prev) hi_q.push_back(streak);
    if (layerDone != 4'd0)  ld_q.push_back(layerDone);
    if (frameDone)          fd_cnt <= fd_cnt + 1;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic tick();
    frameTick = 1'b1;
    cycles(4);
    frameTick = 1'b0;
    cycles(4);
  endtask

  // Waits for a frameDone pulse; an expired budget is reported as a failure.
  task automatic wait_frame_done(input string tag, input int budget);
    int i;
    for (i = 0; i < budget && !frameDone; i++) @(negedge clock);
    if (!frameDone) chk(tag, 32'd0, 32'd1);
  endtask

  initial begin
    int rb, lb, hb, fb;

    // Reset state
    cycles(3);
    chk("rst_draw", draw, 0);
    chk("rst_busy", busy, 0);
    chk("rst_layerDone", layerDone, 0);
    chk("rst_frameDone", frameDone, 0);
    chk("rst_timeoutError", timeoutError, 0);
    chk("rst_xOrigin", xOrigin, 0);
    chk("rst_ROMId", ROMId, 0);
    chk("rst_activeLayer", activeLayer, 0);
    reset_n = 1'b1;
    cycles(3);

    // 1: all layers, engine handshake
    rb = rom_q.size(); lb = ld_q.size(); fb = fd_cnt;
    tick();
    wait_frame_done("t1_frame_timeout", 3000);
    cycles(5);
    chk("t1_draw_count", rom_q.size() - rb, 4);
    chk("t1_rom0", rom_q[rb],   15);
    chk("t1_rom1", rom_q[rb+1], 5);
    chk("t1_rom2", rom_q[rb+2], 1);
    chk("t1_rom3", rom_q[rb+3], 7);
    chk("t1_ld0", ld_q[lb],   4'b0001);
    chk("t1_ld1", ld_q[lb+1], 4'b0010);
    chk("t1_ld2", ld_q[lb+2], 4'b0100);
    chk("t1_ld3", ld_q[lb+3], 4'b1000);
    chk("t1_frames", fd_cnt - fb, 1);
    chk("t1_busy_after", busy, 0);
    chk("t1_xOrigin_last", xOrigin, 40);
    chk("t1_yOrigin_last", yOrigin, 300);
    chk("t1_no_timeout", timeoutError, 0);

    // 2: layers 1 and 3 only
    layerEnable = 4'b1010;
    rb = rom_q.size(); lb = ld_q.size(); fb = fd_cnt;
    tick();
    wait_frame_done("t2_frame_timeout", 3000);
    cycles(5);
    chk("t2_draw_count", rom_q.size() - rb, 2);
    chk("t2_rom0", rom_q[rb],   5);
    chk("t2_rom1", rom_q[rb+1], 7);
    chk("t2_ld_count", ld_q.size() - lb, 4);
    chk("t2_ld0", ld_q[lb],   4'b0001);
    chk("t2_ld1", ld_q[lb+1], 4'b0010);
    chk("t2_ld2", ld_q[lb+2], 4'b0100);
    chk("t2_ld3", ld_q[lb+3], 4'b1000);
    chk("t2_frames", fd_cnt - fb, 1);
    layerEnable = 4'hF;

    // 5: origins held while the bus changes under WAIT_DONE of layer 2
    tick();
    for (int i = 0; i < 3000 && !(activeLayer == 2'd2 && ready == 1'b0); i++) @(negedge clock);
    chk("t5_reach_layer2", {activeLayer, ready}, {2'd2, 1'b0});
    xOriginBus[16 +: 8] = 8'h99;
    xOriginBus[24 +: 8] = 8'h77;
    cycles(5);
    chk("t5_x_held", xOrigin, 30);
    for (int i = 0; i < 3000 && !(draw && activeLayer == 2'd3); i++) @(negedge clock);
    chk("t5_x_layer3", xOrigin, 8'h77);
    wait_frame_done("t5_frame_timeout", 3000);
    xOriginBus = {8'd40, 8'd30, 8'd20, 8'd10};
    cycles(5);

    // 4: three edges in one frame -> exactly one back-to-back frame
    fb = fd_cnt;
    tick();
    cycles(20);
    tick();
    cycles(10);
    tick();
    wait_frame_done("t4_frame1_timeout", 3000);
    @(negedge clock);
    chk("t4_b2b_busy", busy, 1);
    chk("t4_b2b_layer", activeLayer, 0);
    wait_frame_done("t4_frame2_timeout", 3000);
    @(negedge clock);
    chk("t4_idle_busy", busy, 0);
    cycles(40);
    chk("t4_no_third", busy, 0);
    chk("t4_frames", fd_cnt - fb, 2);
`ifdef DRAW_SCHED_OVERRUN_CNT_EN
    chk("t4_overrun", overrunCount, 1);
`endif

    // 6: asynchronous reset during WAIT_DONE of layer 1
    tick();
    for (int i = 0; i < 3000 && !(activeLayer == 2'd1 && ready == 1'b0); i++) @(negedge clock);
    chk("t6_reach_layer1", {activeLayer, ready}, {2'd1, 1'b0});
    @(negedge clock);
    #3 reset_n = 1'b0;
    #1;
    chk("t6_draw", draw, 0);
    chk("t6_busy", busy, 0);
    chk("t6_activeLayer", activeLayer, 0);
    chk("t6_xOrigin", xOrigin, 0);
    chk("t6_ROMId", ROMId, 0);
    chk("t6_layerDone", layerDone, 0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 300 && !(eng_phase == 2'd0 && ready); i++) @(negedge clock);
    cycles(3);
    rb = rom_q.size();
    tick();
    wait_frame_done("t6_frame_timeout", 3000);
    cycles(3);
    chk("t6_restart_count", rom_q.size() - rb, 4);
    chk("t6_restart_rom0", rom_q[rb], 15);

    // 3: engine never accepts -> four 64-cycle timeouts
    eng_on = 1'b0;
    ready_drv = 1'b1;
    hb = hi_q.size(); lb = ld_q.size(); fb = fd_cnt;
    tick();
    wait_frame_done("t3_frame_timeout", 3000);
    cycles(3);
    chk("t3_hi_count", hi_q.size() - hb, 4);
    chk("t3_hi0", hi_q[hb],   64);
    chk("t3_hi1", hi_q[hb+1], 64);
    chk("t3_hi2", hi_q[hb+2], 64);
    chk("t3_hi3", hi_q[hb+3], 64);
    chk("t3_ld0", ld_q[lb],   4'b0001);
    chk("t3_ld3", ld_q[lb+3], 4'b1000);
    chk("t3_frames", fd_cnt - fb, 1);
    chk("t3_timeoutError", timeoutError, 1);
    cycles(50);
    chk("t3_timeout_sticky", timeoutError, 1);
    reset_n = 1'b0;
    #1;
    chk("t3_timeout_cleared", timeoutError, 0);
    @(negedge clock);
    reset_n = 1'b1;
    cycles(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
